// File: rtl/cic_decimator.sv
// ============================================================================
// Module   : cic_decimator
// Purpose  : N-stage Hogenauer CIC decimator (differential delay 1) with
//            run-time power-of-two decimation R = 2**dec_log2, exact gain
//            normalisation by arithmetic shift, and a 1-cycle bypass path.
//            Fixed latency of 2*N_STAGES+1 cycles from the R-th input.
// Ports    : clk        system clock
//            rst_n      asynchronous active-low reset
//            valid_in   cic_in valid this cycle
//            cic_in     signed Q1.15 input sample
//            dec_log2   decimation exponent; values > LOG2_MAX clamp
//            bypass     1: cic_out/valid_out follow inputs, CIC held at 0
//            cic_out    signed Q1.15 decimated sample
//            valid_out  one-cycle strobe per output sample
// Config   : CIC_ROUND_EN defined   -> round half-up before the shift,
//                                      saturate to positive full scale
//            CIC_ROUND_EN undefined -> floor by arithmetic shift
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cic_decimator #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_FRAC  = 15,
    parameter int N_STAGES   = 3,
    parameter int LOG2_MAX   = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 valid_in,
    input  logic signed [DATA_WIDTH-1:0]         cic_in,
    input  logic        [$clog2(LOG2_MAX+1)-1:0] dec_log2,
    input  logic                                 bypass,
    output logic signed [DATA_WIDTH-1:0]         cic_out,
    output logic                                 valid_out
);

    localparam int ACC_WIDTH = DATA_WIDTH + N_STAGES * LOG2_MAX;
    localparam int CFG_W     = $clog2(LOG2_MAX + 1);
    localparam int INT_BITS  = DATA_WIDTH - DATA_FRAC;

    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    // Configuration tracking
    logic [CFG_W-1:0]    dec_clamped;
    logic [CFG_W-1:0]    dec_q;
    logic                bypass_q;
    logic                flush;

    // Datapath state
    acc_t                integ  [N_STAGES];
    acc_t                comb   [N_STAGES];
    acc_t                dly    [N_STAGES];
    logic [N_STAGES-1:0] integ_v;
    logic [N_STAGES-1:0] comb_v;
    logic [LOG2_MAX-1:0] phase;
    logic [LOG2_MAX-1:0] phase_last;
    logic                strobe;

    // Scaling
    int                  shamt;
    acc_t                scaled;
    logic [DATA_WIDTH-1:0] out_next;

    always_comb begin
        dec_clamped = (dec_log2 > CFG_W'(LOG2_MAX)) ? CFG_W'(LOG2_MAX) : dec_log2;
        flush       = (dec_clamped != dec_q) || (bypass != bypass_q);
    end

    // The config copy loads the live inputs during reset so that the first
    // cycle after reset is not mistaken for a configuration change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q    <= dec_clamped;
            bypass_q <= bypass;
        end else if (flush) begin
            dec_q    <= dec_clamped;
            bypass_q <= bypass;
        end
    end

    // R-1 as a thermometer of dec_q ones: avoids a variable shift.
    always_comb begin
        phase_last = '0;
        for (int i = 0; i < LOG2_MAX; i++) begin
            phase_last[i] = (i < int'(dec_q));
        end
        strobe = integ_v[N_STAGES-1] && (phase == phase_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_STAGES; k++) begin
                integ[k] <= '0;
                comb[k]  <= '0;
                dly[k]   <= '0;
            end
            integ_v <= '0;
            comb_v  <= '0;
            phase   <= '0;
        end else if (flush || bypass_q) begin
            // A flush discards the sample of this cycle and everything in flight.
            for (int k = 0; k < N_STAGES; k++) begin
                integ[k] <= '0;
                comb[k]  <= '0;
                dly[k]   <= '0;
            end
            integ_v <= '0;
            comb_v  <= '0;
            phase   <= '0;
        end else begin
            // Integrators at input rate; wrap-around is harmless because the
            // combs recover the exact difference modulo 2**ACC_WIDTH.
            integ_v[0] <= valid_in;
            if (valid_in) begin
                integ[0] <= integ[0] + acc_t'(cic_in);
            end
            for (int k = 1; k < N_STAGES; k++) begin
                integ_v[k] <= integ_v[k-1];
                if (integ_v[k-1]) begin
                    integ[k] <= integ[k] + integ[k-1];
                end
            end

            if (integ_v[N_STAGES-1]) begin
                phase <= strobe ? '0 : phase + LOG2_MAX'(1);
            end

            // Combs at decimated rate.
            comb_v[0] <= strobe;
            if (strobe) begin
                comb[0] <= integ[N_STAGES-1] - dly[0];
                dly[0]  <= integ[N_STAGES-1];
            end
            for (int k = 1; k < N_STAGES; k++) begin
                comb_v[k] <= comb_v[k-1];
                if (comb_v[k-1]) begin
                    comb[k] <= comb[k-1] - dly[k];
                    dly[k]  <= comb[k-1];
                end
            end
        end
    end

    // Gain is exactly R**N = 2**(N*dec_log2), so normalisation is a shift.
`ifdef CIC_ROUND_EN
    localparam acc_t POS_FULL = acc_t'((2 ** (DATA_WIDTH - 1)) - 1);
    acc_t rounded;

    always_comb begin
        shamt   = N_STAGES * int'(dec_q);
        rounded = comb[N_STAGES-1];
        if (shamt > 0) begin
            rounded = comb[N_STAGES-1] + (acc_t'(1) <<< (shamt - 1));
        end
        scaled = rounded >>> shamt;
        // Rounding can only push past full scale on the positive side.
        if (scaled > POS_FULL) begin
            scaled = POS_FULL;
        end
        out_next = (INT_BITS + DATA_FRAC)'(scaled);
    end
`else
    always_comb begin
        shamt    = N_STAGES * int'(dec_q);
        scaled   = comb[N_STAGES-1] >>> shamt;
        // Output word = sign/integer bits plus fraction bits.
        out_next = (INT_BITS + DATA_FRAC)'(scaled);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cic_out   <= '0;
            valid_out <= 1'b0;
        end else if (flush) begin
            valid_out <= 1'b0;
        end else if (bypass_q) begin
            cic_out   <= cic_in;
            valid_out <= valid_in;
        end else begin
            valid_out <= comb_v[N_STAGES-1];
            if (comb_v[N_STAGES-1]) begin
                cic_out <= out_next;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cic_decimator.sv
// ============================================================================
// Module   : tb_cic_decimator
// Purpose  : Directed self-checking bench for cic_decimator. Expected values
//            are hand-computed constants plus a direct-form FIR reference
//            (impulse response of the CIC built by box-filter convolution).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cic_decimator;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               valid_in = 1'b0;
    logic signed [15:0] cic_in = '0;
    logic [2:0]         dec_log2 = 3'd2;
    logic               bypass = 1'b0;
    logic signed [15:0] cic_out;
    logic               valid_out;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int in_v[$];
    int in_c[$];
    int out_v[$];
    int out_c[$];
    int exp_q[$];

    cic_decimator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .cic_in    (cic_in),
        .dec_log2  (dec_log2),
        .bypass    (bypass),
        .cic_out   (cic_out),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && valid_out) begin
            out_v.push_back(int'(cic_out));
            out_c.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        in_v.delete();
        in_c.delete();
        out_v.delete();
        out_c.delete();
    endtask

    // Called at posedge+1; presents one cycle of input and returns at next posedge+1.
    task automatic step(input bit v, input int d, input bit rec = 1'b1);
        logic signed [15:0] s;
        s        = d[15:0];
        valid_in = v;
        cic_in   = s;
        if (v && rec) begin
            in_v.push_back(int'(s));
            in_c.push_back(cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_q();
    endtask

    // Direct-form reference: h = box(R) convolved 3 times, decimated by R.
    task automatic build_model(input int l);
        longint h[$];
        longint t[$];
        longint acc;
        longint y;
        int r;
        int sh;
        r  = 1 << l;
        sh = 3 * l;
        h.delete();
        h.push_back(1);
        repeat (3) begin
            t.delete();
            for (int i = 0; i < h.size() + r - 1; i++) t.push_back(0);
            for (int i = 0; i < h.size(); i++)
                for (int j = 0; j < r; j++) t[i+j] += h[i];
            h = t;
        end
        exp_q.delete();
        for (int n = r - 1; n < in_v.size(); n += r) begin
            acc = 0;
            for (int k = 0; k < h.size(); k++)
                if (n - k >= 0) acc += h[k] * longint'(in_v[n-k]);
`ifdef CIC_ROUND_EN
            if (sh > 0) acc += longint'(1) <<< (sh - 1);
            y = acc >>> sh;
            if (y > 32767) y = 32767;
`else
            y = acc >>> sh;
`endif
            exp_q.push_back(int'(y));
        end
    endtask

    task automatic run_check(input string tag, input int l, input int nexp);
        int n;
        int r;
        r = 1 << l;
        build_model(l);
        n = (nexp < 0) ? exp_q.size() : nexp;
        check($sformatf("%s_count", tag), out_v.size(), n);
        for (int j = 0; j < n && j < out_v.size(); j++) begin
            check($sformatf("%s_val%0d", tag, j), out_v[j], exp_q[j]);
            if ((j + 1) * r - 1 < in_c.size())
                check($sformatf("%s_lat%0d", tag, j), out_c[j] - in_c[(j+1)*r-1], 7);
        end
        clear_q();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_cic_out", int'(cic_out), 0);
        check("rst_valid_out", int'(valid_out), 0);
        rst_n = 1'b1;
        clear_q();

        // Reset mid-stream: output strobe live when reset asserts
        repeat (10) step(1'b1, 16'h4000);
        check("pre_rst_valid", int'(valid_out), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cic_out", int'(cic_out), 0);
        check("mid_rst_valid_out", int'(valid_out), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        valid_in = 1'b0;
        clear_q();
        repeat (8) step(1'b1, 16'h4000);
        idle(12);
        run_check("rst_resume", 2, 2);

        // DC, R=4: positive and negative full-scale
        do_reset();
        repeat (24) step(1'b1, 16'h4000);
        idle(12);
        check("dc_pos_count", out_v.size(), 6);
        for (int j = 3; j < 6 && j < out_v.size(); j++)
            check($sformatf("dc_pos_val%0d", j), out_v[j], 16384);
        run_check("dc_pos", 2, -1);

        do_reset();
        repeat (24) step(1'b1, 16'h8000);
        idle(12);
        check("dc_neg_count", out_v.size(), 6);
        for (int j = 3; j < 6 && j < out_v.size(); j++)
            check($sformatf("dc_neg_val%0d", j), out_v[j], -32768);
        run_check("dc_neg", 2, -1);

        // Impulse, R=2
        dec_log2 = 3'd1;
        do_reset();
        step(1'b1, 16'h7FFF);
        repeat (11) step(1'b1, 0);
        idle(12);
        check("imp_count", out_v.size(), 6);
        if (out_v.size() >= 4) begin
`ifdef CIC_ROUND_EN
            check("imp_val0", out_v[0], 16'h3000);
            check("imp_val1", out_v[1], 16'h1000);
`else
            check("imp_val0", out_v[0], 16'h2FFF);
            check("imp_val1", out_v[1], 16'h0FFF);
`endif
            check("imp_val2", out_v[2], 0);
            check("imp_val3", out_v[3], 0);
        end
        run_check("imp", 1, -1);

        // Gapped input, R=8, valid 1-in-3
        dec_log2 = 3'd3;
        do_reset();
        for (int i = 0; i < 48; i++) begin
            step(1'b1, int'($urandom));
            idle(2);
        end
        idle(12);
        check("gap_count", out_v.size(), 6);
        run_check("gap", 3, -1);

        // Bypass ramp
        bypass = 1'b1;
        step(1'b0, 0, 1'b0);
        clear_q();
        for (int i = 0; i < 256; i++) step(1'b1, i);
        idle(3);
        check("byp_count", out_v.size(), 256);
        for (int j = 0; j < 256 && j < out_v.size(); j++) begin
            check($sformatf("byp_val%0d", j), out_v[j], j);
            check($sformatf("byp_lat%0d", j), out_c[j] - in_c[j], 1);
        end
        bypass = 1'b0;
        step(1'b0, 0, 1'b0);
        clear_q();

        // Config change mid-stream: 2 -> 3 with flush dropping that cycle's input
        dec_log2 = 3'd2;
        do_reset();
        repeat (12) step(1'b1, int'($urandom));
        dec_log2 = 3'd3;
        step(1'b1, 16'h1234, 1'b0);
        check("flush_valid_out", int'(valid_out), 0);
        idle(12);
        run_check("cfg_pre", 2, 1);
        repeat (16) step(1'b1, int'($urandom));
        idle(12);
        run_check("cfg_post", 3, -1);

        // dec_log2=7 clamps to 4; switching 7 -> 4 is not a config change
        dec_log2 = 3'd7;
        step(1'b0, 0, 1'b0);
        clear_q();
        repeat (16) step(1'b1, int'($urandom));
        dec_log2 = 3'd4;
        repeat (16) step(1'b1, int'($urandom));
        idle(12);
        run_check("clamp", 4, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
